// File: rtl/video_frame_monitor.sv
// In-circuit monitor for a sync/RGB video stream. It measures active samples per
// line and lines per frame, counts frames, keeps a rotating RGB checksum and flags unstable timing.
module video_frame_monitor #(
    parameter int RGB_W      = 3,
    parameter int SAMPLE_DIV = 2,
    parameter int CNT_W      = 12,
    parameter int FRAME_W    = 16,
    parameter int MAX_FRAMES = 201,
    parameter int SYNC_POL   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear_err,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [RGB_W-1:0]   rgb,
    output logic [CNT_W-1:0]   line_pixels,
    output logic [CNT_W-1:0]   frame_lines,
    output logic [FRAME_W-1:0] frame_count,
    output logic [15:0]        frame_checksum,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic               done
);
    localparam int                 DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic               SYNC_ACT   = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MAX_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = {CNT_W{1'b1}};

    // Checksum step: rotate left by one, then fold in the zero-extended pixel.
    function automatic logic [15:0] checksum_step(input logic [15:0] acc, input logic [RGB_W-1:0] px);
        return {acc[14:0], acc[15]} ^ 16'(px);
    endfunction

    logic               hs_q_r, vs_q_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [CNT_W-1:0]   pix_cnt_r, line_cnt_r;
    logic [15:0]        sum_r;
    logic               line_valid_r, frame_valid_r;
    logic [CNT_W-1:0]   line_pixels_r, frame_lines_r;
    logic [FRAME_W-1:0] frame_count_r;
    logic [15:0]        frame_checksum_r;
    logic               frame_done_r, line_err_r, frame_err_r, done_r;

    logic               run_s, hs_start_s, vs_start_s, strobe_s, pixel_s;
    logic [CNT_W-1:0]   pix_inc_s, line_next_s;
    logic [15:0]        sum_next_s;
    logic               line_err_set_s, frame_err_set_s;

    // Edge detection, sample strobe and the next-state values shared by line and frame close.
    always_comb begin
        run_s      = enable && !done_r;
        hs_start_s = run_s && (hs_q_r != SYNC_ACT) && (hsync == SYNC_ACT);
        vs_start_s = run_s && (vs_q_r != SYNC_ACT) && (vsync == SYNC_ACT);
        strobe_s   = (div_cnt_r == DIV_LAST);
        pixel_s    = run_s && strobe_s && (hsync != SYNC_ACT) && (vsync != SYNC_ACT);
        pix_inc_s  = (pix_cnt_r == CNT_SAT) ? pix_cnt_r : pix_cnt_r + CNT_W'(1);
        // A line closing in the same cycle as the frame is counted in that frame.
        line_next_s = hs_start_s ? ((line_cnt_r == CNT_SAT) ? line_cnt_r : line_cnt_r + CNT_W'(1))
                                 : line_cnt_r;
        sum_next_s  = pixel_s ? checksum_step(sum_r, rgb) : sum_r;
        line_err_set_s  = hs_start_s && line_valid_r && (pix_cnt_r != {CNT_W{1'b0}})
                          && (pix_cnt_r != line_pixels_r);
        frame_err_set_s = vs_start_s && frame_valid_r && (line_next_s != frame_lines_r);
    end

    // Counters, measurements and sticky flags; everything except the error clears holds while stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q_r           <= !SYNC_ACT;
            vs_q_r           <= !SYNC_ACT;
            div_cnt_r        <= {DIV_W{1'b0}};
            pix_cnt_r        <= {CNT_W{1'b0}};
            line_cnt_r       <= {CNT_W{1'b0}};
            sum_r            <= 16'h0000;
            line_valid_r     <= 1'b0;
            frame_valid_r    <= 1'b0;
            line_pixels_r    <= {CNT_W{1'b0}};
            frame_lines_r    <= {CNT_W{1'b0}};
            frame_count_r    <= {FRAME_W{1'b0}};
            frame_checksum_r <= 16'h0000;
            frame_done_r     <= 1'b0;
            line_err_r       <= 1'b0;
            frame_err_r      <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            line_err_r   <= line_err_set_s  || (line_err_r  && !clear_err);
            frame_err_r  <= frame_err_set_s || (frame_err_r && !clear_err);
            if (run_s) begin
                hs_q_r     <= hsync;
                vs_q_r     <= vsync;
                div_cnt_r  <= (hs_start_s || strobe_s) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
                pix_cnt_r  <= hs_start_s ? {CNT_W{1'b0}} : (pixel_s ? pix_inc_s : pix_cnt_r);
                line_cnt_r <= vs_start_s ? {CNT_W{1'b0}} : line_next_s;
                sum_r      <= vs_start_s ? 16'h0000 : sum_next_s;
                // Blanking and vsync lines carry no samples and never define the reference length.
                if (hs_start_s && (pix_cnt_r != {CNT_W{1'b0}})) begin
                    line_pixels_r <= pix_cnt_r;
                    line_valid_r  <= 1'b1;
                end
                if (vs_start_s) begin
                    frame_lines_r    <= line_next_s;
                    frame_checksum_r <= sum_next_s;
                    frame_count_r    <= frame_count_r + FRAME_W'(1);
                    frame_done_r     <= 1'b1;
                    frame_valid_r    <= 1'b1;
                    done_r           <= (frame_count_r == FRAME_LAST);
                end
            end
        end
    end

    assign line_pixels    = line_pixels_r;
    assign frame_lines    = frame_lines_r;
    assign frame_count    = frame_count_r;
    assign frame_checksum = frame_checksum_r;
    assign frame_done     = frame_done_r;
    assign line_err       = line_err_r;
    assign frame_err      = frame_err_r;
    assign done           = done_r;
endmodule

// File: tb/tb_video_frame_monitor.sv
// Scoreboard bench for video_frame_monitor: the stimulus queues expected frame results,
// and a monitor checks each one on frame_done.
module tb_video_frame_monitor;
    logic        clk = 1'b0;
    logic        reset, enable, clear_err, hsync, vsync;
    logic [2:0]  rgb;
    logic [11:0] line_pixels, frame_lines;
    logic [15:0] frame_count, frame_checksum;
    logic        frame_done, line_err, frame_err, done;

    video_frame_monitor #(.MAX_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .line_pixels(line_pixels), .frame_lines(frame_lines), .frame_count(frame_count),
        .frame_checksum(frame_checksum), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pix;
        logic [11:0] lines;
        logic [15:0] cnt;
        logic [15:0] sum;
        logic        lerr;
        logic        ferr;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [11:0] pix, input logic [11:0] lines, input logic [15:0] cnt,
                                input logic [15:0] sum, input logic le, input logic fe, input logic dn);
        exp_t e;
        e.pix = pix; e.lines = lines; e.cnt = cnt; e.sum = sum; e.lerr = le; e.ferr = fe; e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Monitor: every frame_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=frame_count 0x%0h required=no pulse", frame_count);
            end else begin
                e = exp_q.pop_front();
                chk("frame_line_pixels", 32'(line_pixels), 32'(e.pix));
                chk("frame_lines",       32'(frame_lines), 32'(e.lines));
                chk("frame_count",       32'(frame_count), 32'(e.cnt));
                chk("frame_checksum",    32'(frame_checksum), 32'(e.sum));
                chk("frame_line_err",    32'(line_err), 32'(e.lerr));
                chk("frame_frame_err",   32'(frame_err), 32'(e.ferr));
                chk("frame_done_flag",   32'(done), 32'(e.dn));
            end
        end
    end

    task automatic drive(input logic h, input logic v, input logic [2:0] c);
        hsync = h; vsync = v; rgb = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_line_pixels"},    32'(line_pixels), 32'd0);
        chk({tag, "_frame_lines"},    32'(frame_lines), 32'd0);
        chk({tag, "_frame_count"},    32'(frame_count), 32'd0);
        chk({tag, "_frame_checksum"}, 32'(frame_checksum), 32'd0);
        chk({tag, "_frame_done"},     32'(frame_done), 32'd0);
        chk({tag, "_line_err"},       32'(line_err), 32'd0);
        chk({tag, "_frame_err"},      32'(frame_err), 32'd0);
        chk({tag, "_done"},           32'(done), 32'd0);
    endtask

    // 2-cycle hsync pulse, then n samples of 2 clks each; seq gives rgb 1,2,3.. else rgb=1.
    task automatic send_line(input int n, input logic v, input bit seq, input bit clr);
        for (int i = 0; i < 2; i++) drive(1'b0, v, 3'd0);
        for (int i = 0; i < 2 * n; i++) begin
            clear_err = (clr && i == 4) ? 1'b1 : 1'b0;
            drive(1'b1, v, seq ? 3'(i / 2 + 1) : 3'd1);
        end
        clear_err = 1'b0;
    endtask

    // nact active lines then one vsync line: nact+1 line closes per frame.
    task automatic send_frame(input int nact, input int short_line, input int clr_line);
        for (int l = 1; l <= nact; l++) begin
            if (l == short_line) chk("line_err_clean_before_short", 32'(line_err), 32'd0);
            if (l == clr_line)   chk("line_err_set_by_short_line", 32'(line_err), 32'd1);
            send_line((l == short_line) ? 7 : 8, 1'b1, 1'b0, l == clr_line);
            if (l == clr_line)   chk("line_err_cleared", 32'(line_err), 32'd0);
        end
        send_line(8, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear_err = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        drive(1'b1, 1'b1, 3'd0);

        // One line of samples 1,2,3,4: checksum 1 -> 0 -> 3 -> 2.
        expect_frame(12'd4, 12'd2, 16'd1, 16'h0002, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        send_line(4, 1'b1, 1'b1, 1'b0);
        send_line(8, 1'b0, 1'b0, 1'b0);

        // Mid-line async reset with enable toggling, checked between clock edges.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'd2);
        enable = 1'b1;
        drive(1'b1, 1'b1, 3'd1);
        drive(1'b1, 1'b1, 3'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        hsync = 1'b1; vsync = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 3'd0);

        // Five 10-line frames of 9x8 samples (72 pixels -> 0x00FF); done freezes after the third.
        expect_frame(12'd8, 12'd10, 16'd1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        expect_frame(12'd8, 12'd10, 16'd2, 16'h00FF, 1'b0, 1'b0, 1'b0);
        expect_frame(12'd8, 12'd10, 16'd3, 16'h00FF, 1'b0, 1'b0, 1'b1);
        enable = 1'b1;
        for (int f = 0; f < 5; f++) send_frame(9, 0, 0);
        chk("frozen_done", 32'(done), 32'd1);
        chk("frozen_frame_count", 32'(frame_count), 32'd3);
        chk("frozen_frame_lines", 32'(frame_lines), 32'd10);
        chk("frozen_checksum", 32'(frame_checksum), 32'h00FF);
        chk("queue_empty_after_done", 32'(exp_q.size()), 32'd0);

        reset = 1'b0;
        #1;
        check_all_zero("second_reset");
        enable = 1'b0;
        drive(1'b1, 1'b1, 3'd0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 3'd0);

        // Normal frame, frame with line 5 short (71 px -> 0x007F), then 11-line frame (80 px -> 0xFFFF).
        expect_frame(12'd8, 12'd10, 16'd1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        expect_frame(12'd8, 12'd10, 16'd2, 16'h007F, 1'b0, 1'b0, 1'b0);
        expect_frame(12'd8, 12'd11, 16'd3, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        enable = 1'b1;
        send_frame(9, 0, 0);
        send_frame(9, 5, 7);
        send_frame(10, 0, 0);
        clear_err = 1'b1;
        drive(1'b1, 1'b1, 3'd1);
        clear_err = 1'b0;
        drive(1'b1, 1'b1, 3'd1);
        chk("frame_err_cleared_while_done", 32'(frame_err), 32'd0);
        chk("done_held", 32'(done), 32'd1);
        chk("frame_count_held", 32'(frame_count), 32'd3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
